// File: rtl/fp_regfile_cc_pkg.sv
// Shared constants for the Mini-MIPS FP register file: FP ALU funct codes
// and the init/run state encoding.
package fp_regfile_cc_pkg;

  typedef enum logic [5:0] {
    FUNCT_ADD_S   = 6'd0,
    FUNCT_SUB_S   = 6'd1,
    FUNCT_C_EQ_S  = 6'd2,
    FUNCT_C_LT_S  = 6'd3,
    FUNCT_C_LE_S  = 6'd4,
    FUNCT_C_ULT_S = 6'd5,
    FUNCT_C_ULE_S = 6'd6,
    FUNCT_MOV_S   = 6'd7
  } funct_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/fp_cc_reg.sv
// FP condition-code register: single-bit update per cycle, bypassed bit read,
// asynchronous clear.
module fp_cc_reg #(
  parameter int unsigned NUM_CC = 8,
  localparam int unsigned CW = $clog2(NUM_CC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_en,
  input  logic [CW-1:0]     upd_idx,
  input  logic              upd_val,
  input  logic [CW-1:0]     sel,
  output logic              cc_bit,
  output logic [NUM_CC-1:0] cc_vec
);

  logic [NUM_CC-1:0] cc_q, cc_d;

  always_comb begin
    cc_d = cc_q;
    if (upd_en) cc_d[upd_idx] = upd_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cc_q <= '0;
    else     cc_q <= cc_d;
  end

  // Branch logic sees a compare committing this cycle to the selected bit.
  assign cc_bit = (upd_en && upd_idx == sel) ? upd_val : cc_q[sel];
  assign cc_vec = cc_q;

endmodule

// File: rtl/fp_regfile_cc.sv
// FP register file with CC register: operand reads with write bypass,
// writeback decode, conditional moves, external writes and a post-reset clear sweep.
module fp_regfile_cc #(
  parameter int unsigned NUM_FPR = 32,
  parameter int unsigned NUM_CC  = 8,
  parameter int unsigned DATA_W  = 32,
  localparam int unsigned AW = $clog2(NUM_FPR),
  localparam int unsigned CW = $clog2(NUM_CC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     rs_addr,
  input  logic [AW-1:0]     rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wb_valid,
  input  logic [5:0]        wb_funct,
  input  logic [AW-1:0]     wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  input  logic [NUM_CC-1:0] wb_flags,
  input  logic [CW-1:0]     wb_cc,
  input  logic              wb_movc,
  input  logic              wb_movc_tf,
  input  logic              ext_wr_en,
  input  logic [AW-1:0]     ext_wr_addr,
  input  logic [DATA_W-1:0] ext_wr_data,
  input  logic [CW-1:0]     cc_sel,
  output logic              cc_bit,
  output logic [NUM_CC-1:0] cc_all,
  output logic              ready,
  output logic              ext_conflict
);

  import fp_regfile_cc_pkg::*;

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_FPR - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     clr_idx_q, clr_idx_d;
  logic              ready_q, ready_d;
  logic              ext_conflict_q, ext_conflict_d;
  logic [DATA_W-1:0] fpr_q [NUM_FPR];

  logic              run;
  logic              wb_fpr_we, cmp_we, same_addr, ext_we;
  logic              pa_we;
  logic [AW-1:0]     pa_addr;
  logic [DATA_W-1:0] pa_data;
  logic [NUM_CC-1:0] cc_vec;
  logic              cc_bit_raw;

  assign run = (state_q == ST_RUN);

  // Conditional mov.s tests the registered CC, before any same-cycle compare.
  always_comb begin
    wb_fpr_we = 1'b0;
    cmp_we    = 1'b0;
    if (run && wb_valid) begin
      case (wb_funct)
        FUNCT_ADD_S, FUNCT_SUB_S: wb_fpr_we = 1'b1;
        FUNCT_C_EQ_S, FUNCT_C_LT_S, FUNCT_C_LE_S,
        FUNCT_C_ULT_S, FUNCT_C_ULE_S: cmp_we = 1'b1;
        FUNCT_MOV_S: wb_fpr_we = !wb_movc || (cc_vec[wb_cc] == wb_movc_tf);
        default: ;
      endcase
    end
  end

  assign same_addr = wb_fpr_we && (ext_wr_addr == wb_rd);
  assign ext_we    = run && ext_wr_en && !same_addr;

  always_comb begin
    state_d        = state_q;
    clr_idx_d      = clr_idx_q;
    ready_d        = ready_q;
    ext_conflict_d = run && ext_wr_en && same_addr;
    case (state_q)
      ST_INIT: begin
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == LAST_IDX) begin
          state_d   = ST_RUN;
          ready_d   = 1'b1;
          clr_idx_d = '0;
        end
      end
      ST_RUN: ;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_INIT;
      clr_idx_q      <= '0;
      ready_q        <= 1'b0;
      ext_conflict_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      clr_idx_q      <= clr_idx_d;
      ready_q        <= ready_d;
      ext_conflict_q <= ext_conflict_d;
    end
  end

  // Port A carries the clear sweep during init and writeback results afterwards.
  always_comb begin
    pa_we   = wb_fpr_we;
    pa_addr = wb_rd;
    pa_data = wb_result;
    if (!run) begin
      pa_we   = 1'b1;
      pa_addr = clr_idx_q;
      pa_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (pa_we)  fpr_q[pa_addr]     <= pa_data;
    if (ext_we) fpr_q[ext_wr_addr] <= ext_wr_data;
  end

  always_comb begin
    rs_data = '0;
    if (ready_q) begin
      if (wb_fpr_we && wb_rd == rs_addr)      rs_data = wb_result;
      else if (ext_we && ext_wr_addr == rs_addr) rs_data = ext_wr_data;
      else                                    rs_data = fpr_q[rs_addr];
    end
  end

  always_comb begin
    rt_data = '0;
    if (ready_q) begin
      if (wb_fpr_we && wb_rd == rt_addr)      rt_data = wb_result;
      else if (ext_we && ext_wr_addr == rt_addr) rt_data = ext_wr_data;
      else                                    rt_data = fpr_q[rt_addr];
    end
  end

  fp_cc_reg #(.NUM_CC(NUM_CC)) u_cc (
    .clk     (clk),
    .rst     (rst),
    .upd_en  (cmp_we),
    .upd_idx (wb_cc),
    .upd_val (wb_flags[wb_cc]),
    .sel     (cc_sel),
    .cc_bit  (cc_bit_raw),
    .cc_vec  (cc_vec)
  );

  assign cc_bit       = ready_q && cc_bit_raw;
  assign cc_all       = cc_vec;
  assign ready        = ready_q;
  assign ext_conflict = ext_conflict_q;

endmodule
